// File: rtl/clk_period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_meter_pkg
// Description : Shared FSM encoding and default sizing constants for the
//               clock period meter. Defaults match the divider's count range.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_period_meter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } meter_state_e;

    // Counter width wide enough for the divider's longest COUNT_DIV period
    localparam int unsigned C_DEF_CNT_W   = 41;
    // No rising edge for this many cycles means the input is considered dead
    localparam int unsigned C_DEF_TIMEOUT = 400000000;

endpackage : clk_period_meter_pkg
`default_nettype wire

// File: rtl/clk_period_meter_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Multi-stage synchroniser for an asynchronous input followed by
//               a rising-edge detector. Pin-to-rise latency is SYNC_STAGES+1.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic clear_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   edge_q;
    logic                   edge_d;

    // Shift the async input through the synchroniser chain and keep the
    // previous synchronised value for edge detection
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        edge_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and edge-detect flops
    always_ff @(posedge clk_in or negedge clear_n) begin
        if (!clear_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_meter
// Description : Measures period and high time of a slow square wave in clk_in
//               cycles and hands results out on a valid/ready interface, with
//               sticky overrun and timeout flags.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = C_DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = C_DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             clear_n,
    input  logic             enable,
    input  logic             sig_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             overrun,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic             s;
    logic             rise;

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             en_q, en_d;

    logic             load;
    logic             to_hit;
    logic             en_rise;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in   (clk_in),
        .clear_n  (clear_n),
        .async_in (sig_in),
        .level    (s),
        .rise     (rise)
    );

    // Next-state and counter logic for the measurement FSM
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        load      = 1'b0;
        to_hit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                per_cnt_d = '0;
                hi_cnt_d  = '0;
                state_d   = ST_ARM;
            end
            ST_ARM: begin
                // While waiting for the first edge the period counter doubles
                // as the timeout timer, so a dead input is still reported
                hi_cnt_d = '0;
                if (rise) begin
                    per_cnt_d = C_ONE;
                    hi_cnt_d  = C_ONE;
                    state_d   = ST_MEAS;
                end else if (per_cnt_q == C_TIMEOUT) begin
                    to_hit    = 1'b1;
                    per_cnt_d = '0;
                end else begin
                    per_cnt_d = per_cnt_q + C_ONE;
                end
            end
            ST_MEAS: begin
                if (rise) begin
                    // The edge cycle itself is the first cycle of the next period
                    load      = 1'b1;
                    per_cnt_d = C_ONE;
                    hi_cnt_d  = C_ONE;
                end else if (per_cnt_q == C_TIMEOUT) begin
                    to_hit    = 1'b1;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                    state_d   = ST_ARM;
                end else begin
                    per_cnt_d = per_cnt_q + C_ONE;
                    hi_cnt_d  = hi_cnt_q + {{(CNT_W-1){1'b0}}, s};
                end
            end
            default: begin
                state_d   = ST_IDLE;
                per_cnt_d = '0;
                hi_cnt_d  = '0;
            end
        endcase

        // Disable wins from any state and throws away the partial period
        if (!enable) begin
            state_d   = ST_IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            load      = 1'b0;
            to_hit    = 1'b0;
        end
    end

    // Result register, handshake and sticky flag update
    always_comb begin
        en_d      = enable;
        en_rise   = enable & ~en_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;

        if (load) begin
            period_d = per_cnt_q;
            high_d   = hi_cnt_q;
            valid_d  = 1'b1;
            if (valid_q && !meas_ready) begin
                overrun_d = 1'b1;
            end
        end else if (meas_ready) begin
            valid_d = 1'b0;
        end

        if (to_hit) begin
            timeout_d = 1'b1;
        end

        if (en_rise) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
    end

    // State, counter, result and flag registers
    always_ff @(posedge clk_in or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= ST_IDLE;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            en_q      <= en_d;
        end
    end

    assign meas_valid = valid_q;
    assign period_out = period_q;
    assign high_out   = high_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule : clk_period_meter
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_period_meter
// Description : Directed self-checking bench for clk_period_meter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

    localparam int unsigned CNT_W = 41;

    logic             clk_in = 1'b0;
    logic             clear_n = 1'b0;
    logic             enable = 1'b0;
    logic             sig_in = 1'b0;
    logic             meas_ready = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             overrun;
    logic             timeout;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Wave generator controls
    bit wave_on   = 1'b0;
    bit stuck_val = 1'b0;
    int hi_len    = 5;
    int lo_len    = 5;
    int ph_cnt    = 0;

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2),
        .TIMEOUT     (64)
    ) dut (
        .clk_in     (clk_in),
        .clear_n    (clear_n),
        .enable     (enable),
        .sig_in     (sig_in),
        .meas_ready (meas_ready),
        .meas_valid (meas_valid),
        .period_out (period_out),
        .high_out   (high_out),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clk_in = ~clk_in;

    // Drive sig_in 2 ns after each rising edge so it never races the bench
    initial begin
        forever begin
            @(posedge clk_in);
            #2;
            if (wave_on) begin
                sig_in = (ph_cnt < hi_len);
                ph_cnt = (ph_cnt + 1 >= hi_len + lo_len) ? 0 : ph_cnt + 1;
            end else begin
                sig_in = stuck_val;
                ph_cnt = 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_in);
    endtask

    // Wait (bounded) for meas_valid at a falling edge
    task automatic wait_valid(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_in);
            if (meas_valid) break;
        end
        check_eq({tag, "_valid"}, 64'(meas_valid), 64'd1);
    endtask

    initial begin
        int pulses;

        // ---- reset state ----
        wait_cycles(3);
        check_eq("rst_valid", 64'(meas_valid), 64'd0);
        check_eq("rst_period", 64'(period_out), 64'd0);
        check_eq("rst_high", 64'(high_out), 64'd0);
        check_eq("rst_overrun", 64'(overrun), 64'd0);
        check_eq("rst_timeout", 64'(timeout), 64'd0);

        // ---- 5/5 wave, consumer always ready ----
        clear_n    = 1'b1;
        meas_ready = 1'b1;
        hi_len     = 5;
        lo_len     = 5;
        wave_on    = 1'b1;
        wait_cycles(2);
        enable = 1'b1;
        wait_valid("w55", 100);
        check_eq("w55_period", 64'(period_out), 64'd10);
        check_eq("w55_high", 64'(high_out), 64'd5);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (meas_valid) pulses++;
        end
        check_eq("w55_pulses", 64'(pulses), 64'd4);
        check_eq("w55_overrun", 64'(overrun), 64'd0);

        // ---- 3/9 duty, then stall consumer for two periods ----
        hi_len = 3;
        lo_len = 9;
        wait_cycles(50);
        wait_valid("w39", 40);
        check_eq("w39_period", 64'(period_out), 64'd12);
        check_eq("w39_high", 64'(high_out), 64'd3);
        meas_ready = 1'b0;
        wait_cycles(30);
        check_eq("ovr_flag", 64'(overrun), 64'd1);
        check_eq("ovr_valid", 64'(meas_valid), 64'd1);
        check_eq("ovr_period", 64'(period_out), 64'd12);
        check_eq("ovr_high", 64'(high_out), 64'd3);
        meas_ready = 1'b1;
        wait_cycles(1);
        check_eq("ovr_consumed", 64'(meas_valid), 64'd0);

        // ---- enable dropped mid-period then re-raised ----
        hi_len = 5;
        lo_len = 5;
        wait_cycles(23);
        enable = 1'b0;
        wait_cycles(7);
        enable = 1'b1;
        wait_cycles(1);
        check_eq("rearm_overrun", 64'(overrun), 64'd0);
        check_eq("rearm_timeout", 64'(timeout), 64'd0);
        check_eq("rearm_valid", 64'(meas_valid), 64'd0);
        wait_valid("rearm", 60);
        check_eq("rearm_period", 64'(period_out), 64'd10);

        // ---- ready asserted in the same cycle a new result loads ----
        wait_cycles(2);
        meas_ready = 1'b0;
        wait_valid("same", 30);
        wait_cycles(9);
        meas_ready = 1'b1;
        wait_cycles(1);
        check_eq("same_valid", 64'(meas_valid), 64'd1);
        check_eq("same_period", 64'(period_out), 64'd10);
        check_eq("same_overrun", 64'(overrun), 64'd0);
        wait_cycles(1);
        check_eq("same_consumed", 64'(meas_valid), 64'd0);

        // ---- single pulse then stuck low: timeout 64 cycles into MEAS ----
        enable    = 1'b0;
        wave_on   = 1'b0;
        stuck_val = 1'b0;
        wait_cycles(3);
        enable = 1'b1;
        wait_cycles(2);
        stuck_val = 1'b1;
        for (int n = 1; n <= 68; n++) begin
            @(negedge clk_in);
            if (n == 3) stuck_val = 1'b0;
            if (n == 67) check_eq("to_before", 64'(timeout), 64'd0);
            if (n == 68) check_eq("to_at", 64'(timeout), 64'd1);
        end
        check_eq("to_no_result", 64'(meas_valid), 64'd0);

        // ---- toggling restored: results resume, timeout stays sticky ----
        wave_on = 1'b1;
        wait_valid("resume", 60);
        check_eq("resume_period", 64'(period_out), 64'd10);
        check_eq("resume_high", 64'(high_out), 64'd5);
        check_eq("resume_timeout", 64'(timeout), 64'd1);

        // ---- asynchronous clear mid-measurement ----
        meas_ready = 1'b0;
        wait_cycles(15);
        check_eq("pre_clr_valid", 64'(meas_valid), 64'd1);
        #2 clear_n = 1'b0;
        #1;
        check_eq("clr_valid", 64'(meas_valid), 64'd0);
        check_eq("clr_period", 64'(period_out), 64'd0);
        check_eq("clr_high", 64'(high_out), 64'd0);
        check_eq("clr_timeout", 64'(timeout), 64'd0);
        check_eq("clr_overrun", 64'(overrun), 64'd0);
        @(negedge clk_in);
        meas_ready = 1'b1;
        clear_n    = 1'b1;
        wait_cycles(3);
        check_eq("post_clr_valid", 64'(meas_valid), 64'd0);
        wait_valid("post_clr", 60);
        check_eq("post_clr_period", 64'(period_out), 64'd10);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_clk_period_meter
`default_nettype wire

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receive-side counterpart of the clock divider: measures a slow square wave and recovers its period and high time in clk_in cycles, the inverse of the divider's count-to-frequency mapping.
- Used on board to check divider outputs (e.g. VGA pixel/frame ticks) and external slow clocks.
- Results are delivered on a valid/ready handshake to a display or debug consumer.

Parameters:
- CNT_W, 41, width of period/high counters and result buses.
- SYNC_STAGES, 2, flip-flop stages in the sig_in synchroniser (min 2).
- TIMEOUT, 400000000, clk_in cycles without a rising edge before a timeout is declared (must be < 2^CNT_W).

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- clear_n  input  1  asynchronous, active-low reset.
- enable  input  1  measurement enable; low forces IDLE.
- sig_in  input  1  measured signal, asynchronous to clk_in.
- meas_ready  input  1  consumer accepts the result when high with meas_valid.
- meas_valid  output  1  a result is held on period_out/high_out.
- period_out  output  CNT_W  cycles between consecutive rising edges.
- high_out  output  CNT_W  cycles sig_in was high within that period.
- overrun  output  1  sticky: a result was overwritten before being accepted.
- timeout  output  1  sticky: TIMEOUT elapsed with no rising edge.

Behaviour:
- Reset: clk_in and clear_n, one clock; reset is asynchronous and active-low. While clear_n=0, all outputs, counters, synchroniser and FSM are 0/IDLE.
- Synchroniser: sig_in passes SYNC_STAGES flops, then one extra flop for edge detection. rise = s & ~s_q. Pin-to-rise latency is SYNC_STAGES+1 cycles, the same for every edge, so it does not affect results.
- FSM states and transitions:
  - IDLE: counters held at 0. Go to ARM when enable=1.
  - ARM: wait for the first rise. On rise, set per_cnt=1 and hi_cnt=1, then go to MEAS.
  - MEAS: each cycle per_cnt += 1, and hi_cnt += 1 when s=1.
    - On rise: latch period_out=per_cnt and high_out=hi_cnt, restart per_cnt=1 and hi_cnt=1, stay in MEAS. Back-to-back periods are measured with no gap.
    - When per_cnt reaches TIMEOUT with no rise: set timeout=1 (sticky), discard the partial count, go to ARM.
  - Any state: enable=0 goes to IDLE next cycle and discards the partial count. A held result is kept.
- Result timing: period_out, high_out and meas_valid update in the cycle after the rise that closes the period.
- Handshake:
  - meas_valid stays 1 until a cycle with meas_ready=1, then clears next cycle unless a new result loads in that same cycle.
  - New result with meas_valid=1 and meas_ready=0: overwrite the result and set overrun=1.
  - New result in the same cycle as meas_ready=1: load it, meas_valid stays 1, no overrun.
  - Data is stable whenever meas_valid=1 and no load occurs.
- Sticky flags: overrun and timeout clear only on clear_n=0 or on the rising edge of enable.
- Width: counters never exceed TIMEOUT, so there is no wrap. high_out ≤ period_out always.
- A constant sig_in (stuck 0 or stuck 1) always ends in timeout and never produces a result.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, ARM=2'd1, MEAS=2'd2);
  - default CNT_W and TIMEOUT constants, kept consistent with the divider's COUNT_DIV range.
- One sub-module, sync_edge_det: SYNC_STAGES synchroniser plus rise detector, reusable for buttons and other async inputs.

Test Plan:
- Divider-style wave, half period 5 clk_in cycles, enable=1, meas_ready=1 → after the second rise: period_out=10, high_out=5, meas_valid pulses once per 10 cycles.
- Duty test: sig_in high 3, low 9, repeating → period_out=12, high_out=3. Hold meas_ready=0 across two periods → overrun=1 and the latest value is held.
- sig_in stuck 0 with TIMEOUT=64 → timeout=1 exactly 64 cycles after entering MEAS (or ARM timeout after the first rise), meas_valid stays 0. Restore toggling → measurements resume, timeout stays 1 until enable is toggled.
- meas_ready asserted in the same cycle a new result loads → meas_valid stays 1, new data present, overrun=0.
- enable dropped mid-period, then re-raised → no partial result. The first result after re-arm equals the true period (e.g. 10). Sticky flags are cleared.
- clear_n pulsed low mid-MEAS, asynchronously between clk_in edges → all outputs 0 immediately; after release the FSM starts in IDLE.
